// File: rtl/wb_burst_reader.sv
// Pipelined Wishbone burst-read master: issues one read per word under a credit
// limit (in-flight + buffered <= DEPTH) and streams returned words through a FIFO.
module wb_burst_reader #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_L   = 4,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned ADDR_INC = 1,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    output logic                busy,
    output logic                done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_L*8-1:0] out_data,
    output logic                wb_cyc,
    output logic                wb_stb,
    input  logic                wb_stall,
    input  logic                wb_ack,
    output logic [ADDR_W-1:0]   wb_adr,
    output logic [DATA_L*8-1:0] wb_dat_w,
    input  logic [DATA_L*8-1:0] wb_dat_r,
    output logic                wb_we,
    output logic [DATA_L-1:0]   wb_sel
);
    localparam int unsigned DATA_W = DATA_L * 8;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned CRD_W  = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic [ADDR_W-1:0]  adr_q, adr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [CNT_W-1:0]   infl_q, infl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               issue;
    logic               push;
    logic               pop;
    logic [CRD_W-1:0]   credit_d;
    logic               room;

    // Next-state, counters and burst control
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = 1'b0;
        adr_d       = adr_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        cmd_ready_d = cmd_ready_q;

        issue    = stb_q && !wb_stall;
        push     = wb_ack && (infl_q != '0);
        pop      = out_valid_q && out_ready;
        infl_d   = infl_q + CNT_W'(issue) - CNT_W'(push);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        credit_d = CRD_W'(infl_d) + CRD_W'(cnt_d);
        room     = credit_d < CRD_W'(DEPTH);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        out_valid_d = (cnt_d != '0);
        out_data_d  = out_data_q;
        // A word pushed into an otherwise empty FIFO becomes the head directly
        if (cnt_d != '0) begin
            out_data_d = (push && ((cnt_q - CNT_W'(pop)) == '0)) ? wb_dat_r : mem_q[rd_ptr_d];
        end

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                cyc_d       = 1'b0;
                busy_d      = 1'b0;
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        cyc_d       = 1'b1;
                        busy_d      = 1'b1;
                        cmd_ready_d = 1'b0;
                        adr_d       = cmd_addr;
                        rem_d       = cmd_len;
                        stb_d       = room;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    adr_d = adr_q + ADDR_W'(ADDR_INC);
                    rem_d = rem_q - LEN_W'(1);
                end
                if (rem_d == '0) begin
                    state_d = DRAIN;
                end else begin
                    stb_d = room;
                end
            end
            DRAIN: begin
                if (infl_d == '0) begin
                    state_d     = IDLE;
                    cyc_d       = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            adr_q       <= '0;
            rem_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            infl_q      <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            adr_q       <= adr_d;
            rem_q       <= rem_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            infl_q      <= infl_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by cnt_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wb_dat_r;
        end
    end

    // An ack with nothing outstanding is a slave protocol error
    always_ff @(posedge clk) begin
        if (rst_n && wb_ack) begin
            assert (infl_q != '0);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign wb_cyc    = cyc_q;
    assign wb_stb    = stb_q;
    assign wb_adr    = adr_q;
    assign wb_dat_w  = '0;
    assign wb_we     = 1'b0;
    assign wb_sel    = '1;

endmodule
